// File: rtl/sd4_mac_pkg.sv
// Shared constants and types for the SD4 MAC datapath.
// SUM_W  : unsigned MAC sum magnitude width
// LEAD_W : leading-one index width (also the exponent width)
// MAN_W  : stored mantissa bits (hidden one not stored)
// norm_word_t : normalized result bundle {sign, zero, exp, man}
package sd4_mac_pkg;

    localparam int unsigned SUM_W  = 20;
    localparam int unsigned LEAD_W = 5;
    localparam int unsigned MAN_W  = 7;

    typedef struct packed {
        logic              sign;
        logic              zero;
        logic [LEAD_W-1:0] exp;
        logic [MAN_W-1:0]  man;
    } norm_word_t;

endpackage

// File: rtl/sd4_rne_round.sv
// Round-to-nearest-even of an already aligned fraction.
// frac_i   : fraction bits below the hidden one
// guard_i  : first bit below the fraction
// sticky_i : OR of all bits below guard
// lead_i   : leading-one index of the unrounded value
// man_o    : rounded fraction
// exp_o    : exponent, bumped by one when the fraction rolls over
module sd4_rne_round #(
    parameter int unsigned ManW  = 7,
    parameter int unsigned LeadW = 5
) (
    input  logic [ManW-1:0]  frac_i,
    input  logic             guard_i,
    input  logic             sticky_i,
    input  logic [LeadW-1:0] lead_i,
    output logic [ManW-1:0]  man_o,
    output logic [LeadW-1:0] exp_o
);

    logic            round_up;
    logic [ManW:0]   frac_sum;

    always_comb begin
        round_up = guard_i & (sticky_i | frac_i[0]);
        frac_sum = {1'b0, frac_i} + {{ManW{1'b0}}, round_up};
        // On roll-over the low bits are already zero: 1.111..1 + ulp = 10.000..0
        man_o    = frac_sum[ManW-1:0];
        exp_o    = lead_i + LeadW'(frac_sum[ManW]);
    end

endmodule

// File: rtl/sd4_sum_normalizer.sv
// Normalizes and rounds the unsigned MAC sum into a sign/exponent/mantissa word.
// Two-register valid/ready pipeline: stage 1 aligns, stage 2 rounds into the output register.
// clk, rst_n             : clock, async active-low reset
// in_valid_i/in_ready_o  : input handshake
// in_sign_i, in_mag_i    : signed-magnitude sum
// in_lead_i              : leading-one index of in_mag_i
// out_valid_o/out_ready_i: output handshake
// out_sign_o, out_exp_o, out_man_o, out_zero_o : normalized result
// lead_err_o             : sticky flag, leading-one index inconsistent with magnitude
// err_clr_i              : synchronous clear of lead_err_o (a same-cycle set wins)
module sd4_sum_normalizer
    import sd4_mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_sign_i,
    input  logic [SUM_W-1:0]  in_mag_i,
    input  logic [LEAD_W-1:0] in_lead_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_sign_o,
    output logic [LEAD_W-1:0] out_exp_o,
    output logic [MAN_W-1:0]  out_man_o,
    output logic              out_zero_o,
    output logic              lead_err_o,
    input  logic              err_clr_i
);

    // Bits strictly below the normalized leading one.
    localparam int unsigned AlW = SUM_W - 1;

    // Stage-1 alignment (combinational on the input beat)
    logic [AlW-1:0]   below;
    logic [SUM_W-1:0] mag_hi;
    logic             in_zero;
    logic             in_err;
    logic [MAN_W-1:0] in_frac;
    logic             in_guard;
    logic             in_sticky;

    always_comb begin
        // Appending AlW zeros then shifting right by lead is a left shift by AlW-lead;
        // anything above the claimed leading one falls off the top.
        below     = AlW'({in_mag_i, {AlW{1'b0}}} >> in_lead_i);
        in_frac   = below[AlW-1 -: MAN_W];
        in_guard  = below[AlW-1-MAN_W];
        in_sticky = |below[AlW-2-MAN_W:0];
        in_zero   = (in_mag_i == '0);
        // Consistent lead means exactly the single bit at in_lead survives this shift.
        mag_hi    = in_mag_i >> in_lead_i;
        in_err    = !in_zero && (mag_hi != SUM_W'(1));
    end

    // Handshake
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic in_accept;
    logic out_free;
    logic s1_adv;

    always_comb begin
        out_free    = ~out_valid_q | out_ready_i;
        s1_adv      = s1_valid_q & out_free;
        in_ready_o  = ~s1_valid_q | out_free;
        in_accept   = in_valid_i & in_ready_o;
        s1_valid_d  = in_accept | (s1_valid_q & ~s1_adv);
        out_valid_d = s1_adv | (out_valid_q & ~out_ready_i);
    end

    // Stage-1 registers
    logic              s1_sign_q;
    logic              s1_zero_q;
    logic [LEAD_W-1:0] s1_lead_q;
    logic [MAN_W-1:0]  s1_frac_q;
    logic              s1_guard_q;
    logic              s1_sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_lead_q   <= '0;
            s1_frac_q   <= '0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_accept) begin
                s1_sign_q   <= in_sign_i;
                s1_zero_q   <= in_zero;
                s1_lead_q   <= in_lead_i;
                s1_frac_q   <= in_frac;
                s1_guard_q  <= in_guard;
                s1_sticky_q <= in_sticky;
            end
        end
    end

    // Stage 2: rounding
    logic [MAN_W-1:0]  rnd_man;
    logic [LEAD_W-1:0] rnd_exp;

    sd4_rne_round #(
        .ManW  (MAN_W),
        .LeadW (LEAD_W)
    ) u_round (
        .frac_i   (s1_frac_q),
        .guard_i  (s1_guard_q),
        .sticky_i (s1_sticky_q),
        .lead_i   (s1_lead_q),
        .man_o    (rnd_man),
        .exp_o    (rnd_exp)
    );

    norm_word_t out_q, out_d;

    always_comb begin
        out_d = out_q;
        if (s1_adv) begin
            if (s1_zero_q) begin
                // Zero is canonical: positive, exponent and mantissa cleared.
                out_d.sign = 1'b0;
                out_d.zero = 1'b1;
                out_d.exp  = '0;
                out_d.man  = '0;
            end else begin
                out_d.sign = s1_sign_q;
                out_d.zero = 1'b0;
                out_d.exp  = rnd_exp;
                out_d.man  = rnd_man;
            end
        end
    end

    // Sticky error flag
    logic lead_err_q, lead_err_d;

    always_comb begin
        lead_err_d = lead_err_q;
        if (in_accept && in_err) begin
            lead_err_d = 1'b1;
        end else if (err_clr_i) begin
            lead_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            lead_err_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            lead_err_q  <= lead_err_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_sign_o  = out_q.sign;
    assign out_zero_o  = out_q.zero;
    assign out_exp_o   = out_q.exp;
    assign out_man_o   = out_q.man;
    assign lead_err_o  = lead_err_q;

endmodule

// File: tb/tb_sd4_sum_normalizer.sv
// Self-checking bench for sd4_sum_normalizer: value-level rounding model plus scoreboard,
// with directed vectors pinned by hand-computed literals.
module tb_sd4_sum_normalizer;
    import sd4_mac_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_sign = 1'b0;
    logic [SUM_W-1:0]  in_mag = '0;
    logic [LEAD_W-1:0] in_lead = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_sign;
    logic [LEAD_W-1:0] out_exp;
    logic [MAN_W-1:0]  out_man;
    logic              out_zero;
    logic              lead_err;
    logic              err_clr = 1'b0;

    always #5 clk = ~clk;

    sd4_sum_normalizer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_sign_i   (in_sign),
        .in_mag_i    (in_mag),
        .in_lead_i   (in_lead),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sign_o  (out_sign),
        .out_exp_o   (out_exp),
        .out_man_o   (out_man),
        .out_zero_o  (out_zero),
        .lead_err_o  (lead_err),
        .err_clr_i   (err_clr)
    );

    typedef struct {
        logic sign;
        logic zero;
        int   exp;
        int   man;
    } res_t;

    res_t exp_q[$];
    logic err_m = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Value-level rounding: keep the MAN_W bits under the leading one, compare the
    // discarded remainder against one half ulp, ties go to an even fraction.
    function automatic res_t model(input logic sign, input int mag, input int lead);
        res_t r;
        int   sh, frac, rem, half;
        bit   up;
        if (mag == 0) begin
            r.sign = 1'b0; r.zero = 1'b1; r.exp = 0; r.man = 0;
            return r;
        end
        up = 1'b0;
        if (lead >= MAN_W) begin
            sh   = lead - MAN_W;
            frac = (mag >> sh) % (1 << MAN_W);
            if (sh > 0) begin
                rem  = mag % (1 << sh);
                half = 1 << (sh - 1);
                up   = (rem > half) || (rem == half && (frac % 2) == 1);
            end
        end else begin
            frac = (mag << (MAN_W - lead)) % (1 << MAN_W);
        end
        frac  = frac + int'(up);
        r.exp = lead;
        if (frac == (1 << MAN_W)) begin
            frac  = 0;
            r.exp = lead + 1;
        end
        r.man  = frac;
        r.sign = sign;
        r.zero = 1'b0;
        return r;
    endfunction

    function automatic bit model_err(input int mag, input int lead);
        return (mag != 0) && ((mag >> lead) != 1);
    endfunction

    // Scoreboard bookkeeping on the active edge (sees pre-edge values).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            err_m = 1'b0;
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_sign, int'(in_mag), int'(in_lead)));
                if (model_err(int'(in_mag), int'(in_lead))) err_m = 1'b1;
                else if (err_clr) err_m = 1'b0;
            end else if (err_clr) begin
                err_m = 1'b0;
            end
        end
    end

    // Compare on the falling edge whenever outputs are meaningful.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got out_valid=1, expected no pending beat (t=%0t)",
                             $time);
                end else begin
                    if (out_sign !== exp_q[0].sign || out_zero !== exp_q[0].zero ||
                        int'(out_exp) != exp_q[0].exp || int'(out_man) != exp_q[0].man) begin
                        n_fail++;
                        $display("FAIL result: got s=%0d z=%0d e=%0d m=0x%0h, expected s=%0d z=%0d e=%0d m=0x%0h (t=%0t)",
                                 out_sign, out_zero, out_exp, out_man, exp_q[0].sign,
                                 exp_q[0].zero, exp_q[0].exp, exp_q[0].man, $time);
                    end
                end
            end
            check("lead_err_model", lead_err, err_m);
        end
    end

    task automatic send(input logic s, input logic [SUM_W-1:0] m, input logic [LEAD_W-1:0] l);
        bit acc;
        int tries;
        tries = 0;
        in_valid = 1'b1; in_sign = s; in_mag = m; in_lead = l;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            tries++;
        end while (!acc && tries < 50);
        if (!acc) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: got no accept in %0d cycles, expected accept", tries);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || out_valid) && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    typedef struct {
        logic             sign;
        logic [SUM_W-1:0] mag;
        logic [LEAD_W-1:0] lead;
        int               man;
        int               exp;
        logic             zero;
    } vec_t;

    vec_t vecs[9] = '{
        '{1'b0, 20'h00302, 5'd9,  'h40, 9,  1'b0},  // tie, even stays
        '{1'b1, 20'h00306, 5'd9,  'h42, 9,  1'b0},  // tie, odd rounds up
        '{1'b0, 20'h000FF, 5'd7,  'h7F, 7,  1'b0},  // exact
        '{1'b0, 20'h001FF, 5'd8,  'h00, 9,  1'b0},  // roll-over
        '{1'b1, 20'hFFFFF, 5'd19, 'h00, 20, 1'b0},  // max exponent
        '{1'b1, 20'h00000, 5'd0,  'h00, 0,  1'b1},  // zero, sign dropped
        '{1'b0, 20'h00005, 5'd2,  'h20, 2,  1'b0},  // small, zero-filled
        '{1'b0, 20'h00303, 5'd9,  'h41, 9,  1'b0},  // above half
        '{1'b1, 20'h00C09, 5'd11, 'h41, 11, 1'b0}   // sticky breaks the tie
    };

    vec_t bp[4] = '{
        '{1'b0, 20'h12345, 5'd16, 0, 0, 1'b0},
        '{1'b1, 20'h00ABC, 5'd11, 0, 0, 1'b0},
        '{1'b0, 20'h7FFFF, 5'd18, 0, 0, 1'b0},
        '{1'b1, 20'h00001, 5'd0,  0, 0, 1'b0}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        res_t r;
        int   idx;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_exp", out_exp, 0);
        check("rst_out_man", out_man, 0);
        check("rst_out_sign", out_sign, 0);
        check("rst_out_zero", out_zero, 0);
        check("rst_lead_err", lead_err, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic normalization and latency: driven in cycle 0, visible in cycle 2
        out_ready = 1'b1;
        in_valid = 1'b1; in_sign = 1'b1; in_mag = 20'h80000; in_lead = 5'd19;
        @(negedge clk);
        check("basic_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("basic_not_yet", out_valid, 0);
        @(negedge clk);
        check("basic_valid", out_valid, 1);
        check("basic_exp", out_exp, 19);
        check("basic_man", out_man, 0);
        check("basic_sign", out_sign, 1);
        check("basic_zero", out_zero, 0);
        drain();

        // Directed rounding vectors; each model result pinned to a literal first
        foreach (vecs[i]) begin
            r = model(vecs[i].sign, int'(vecs[i].mag), int'(vecs[i].lead));
            check("pin_man", r.man, vecs[i].man);
            check("pin_exp", r.exp, vecs[i].exp);
            check("pin_zero", r.zero, vecs[i].zero);
        end
        foreach (vecs[i]) send(vecs[i].sign, vecs[i].mag, vecs[i].lead);
        drain();
        check("no_err_after_clean", lead_err, 0);

        // Backpressure: 4 beats offered while the consumer stalls
        out_ready = 1'b0;
        idx = 0;
        repeat (5) begin
            in_valid = 1'b1; in_sign = bp[idx].sign; in_mag = bp[idx].mag; in_lead = bp[idx].lead;
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("bp_accepts", idx, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_held", exp_q.size(), 2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        while (idx < 4) begin
            send(bp[idx].sign, bp[idx].mag, bp[idx].lead);
            idx++;
        end
        drain();

        // Sticky error flag
        send(1'b0, 20'h00010, 5'd19);
        drain();
        check("err_set", lead_err, 1);
        repeat (3) @(posedge clk);
        #1;
        check("err_persist", lead_err, 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("err_cleared", lead_err, 0);
        err_clr = 1'b1;
        send(1'b0, 20'h00030, 5'd4);  // bit 4 set but bit 5 also set
        err_clr = 1'b0;
        check("err_set_wins", lead_err, 1);
        drain();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("err_cleared2", lead_err, 0);

        // Asynchronous reset with two beats in flight
        out_ready = 1'b0;
        send(1'b1, 20'h0F0F0, 5'd15);
        send(1'b0, 20'h00800, 5'd3);   // inconsistent lead
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_err", lead_err, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_exp", out_exp, 0);
        check("rst_mid_man", out_man, 0);
        check("rst_mid_sign", out_sign, 0);
        check("rst_mid_err", lead_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("post_rst_in_ready", in_ready, 1);
        repeat (4) begin
            @(negedge clk);
            check("post_rst_no_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        send(1'b0, 20'h00306, 5'd9);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
